grf_32x32: RTL and testbench

- General register file for the single-cycle MIPS datapath: 32 registers, 32 bits each.
- Two asynchronous read ports and one synchronous write port.
- Write port is the demultiplexing counterpart of the datapath selectors:
  - write address arrives from the 3:1 5-bit register-destination select (rt/rd/31);
  - write data arrives from the 2:1 32-bit write-back select;
  - the block decodes the address into per-register write enables.
- Register $0 is hardwired to zero.
- Every committed write is logged for trace comparison against the reference simulator.

---
 rtl/mips_pkg.sv | 15 +
 rtl/grf_wdec.sv | 21 ++
 rtl/grf_32x32.sv | 66 ++++++
 tb/tb_grf_32x32.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: widths, named register indices and the
// RegDst encodings used by the destination select feeding the register file.
package mips_pkg;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

   typedef enum logic [1:0] {
      REGDST_RT = 2'b00,
      REGDST_RD = 2'b01,
      REGDST_RA = 2'b10
   } regdst_e;
endpackage

// File: rtl/grf_wdec.sv
// One-hot write-enable decoder for the register file; $0 is never enabled.
module grf_wdec
   import mips_pkg::*;
#(
   parameter int AW = ADDR_W
) (
   input  logic              we,
   input  logic [AW-1:0]     wa,
   output logic [2**AW-1:0]  en
);
   genvar gi;
   generate
      for (gi = 0; gi < 2**AW; gi++) begin : g_en
         if (gi == int'(REG_ZERO)) begin : g_zero
            assign en[gi] = 1'b0;
         end else begin : g_reg
            assign en[gi] = we && (wa == AW'(gi));
         end
      end
   endgenerate
endmodule

// File: rtl/grf_32x32.sv
// 32x32 MIPS general register file: two combinational read ports, one
// synchronous write port, hardwired $0, optional write-through bypass.
module grf_32x32
   import mips_pkg::*;
#(
   parameter int DW           = DATA_W,
   parameter int AW           = ADDR_W,
   parameter bit WRITE_BYPASS = 1'b1,
   parameter bit TRACE_EN     = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic [31:0]   pc,
   output logic          trace_valid,
   output logic [31:0]   trace_pc,
   output logic [AW-1:0] trace_wa,
   output logic [DW-1:0] trace_wd
);
   localparam int DEPTH = 2**AW;

   logic [DW-1:0]    regs_reg [DEPTH];
   logic [DEPTH-1:0] en;
   logic             commit;

   grf_wdec #(.AW(AW)) u_wdec (
      .we (we),
      .wa (wa),
      .en (en)
   );

   // Reset wins over a simultaneous write, so the write is neither stored nor traced.
   assign commit = (|en) && !reset;

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (reset) begin
            regs_reg[i] <= '0;
         end else if (en[i]) begin
            regs_reg[i] <= wd;
         end
      end
   end

   always_comb begin
      rd1 = regs_reg[ra1];
      rd2 = regs_reg[ra2];
      if (WRITE_BYPASS && commit && (wa == ra1)) rd1 = wd;
      if (WRITE_BYPASS && commit && (wa == ra2)) rd2 = wd;
      // $0 may hold X before the first reset; force it here instead.
      if (ra1 == REG_ZERO) rd1 = '0;
      if (ra2 == REG_ZERO) rd2 = '0;
   end

   // Commit record for the trace log, valid during the cycle whose edge commits it.
   assign trace_valid = TRACE_EN && commit;
   assign trace_pc    = pc;
   assign trace_wa    = wa;
   assign trace_wd    = wd;
endmodule

// File: tb/tb_grf_32x32.sv
// Scoreboard bench for grf_32x32: one bypassing and one non-bypassing instance
// share stimulus; expected read data is queued by the driver and checked at negedge.
module tb_grf_32x32;
   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  ra1, ra2, wa;
   logic        we;
   logic [31:0] wd, pc;

   logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
   logic        b_tv, n_tv;
   logic [31:0] b_tpc, n_tpc, b_twd, n_twd;
   logic [4:0]  b_twa, n_twa;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      string       name;
      logic [31:0] e1, e2, n1, n2;
      logic        tv;
      logic [31:0] tpc, twd;
      logic [4:0]  twa;
   } exp_t;

   exp_t sb_q[$];
   logic [31:0] model[32];

   always #5 clk = ~clk;

   grf_32x32 #(.WRITE_BYPASS(1'b1), .TRACE_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2),
      .we(we), .wa(wa), .wd(wd), .pc(pc),
      .trace_valid(b_tv), .trace_pc(b_tpc), .trace_wa(b_twa), .trace_wd(b_twd)
   );

   grf_32x32 #(.WRITE_BYPASS(1'b0), .TRACE_EN(1'b1)) dut_nb (
      .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(n_rd1), .rd2(n_rd2),
      .we(we), .wa(wa), .wd(wd), .pc(pc),
      .trace_valid(n_tv), .trace_pc(n_tpc), .trace_wa(n_twa), .trace_wd(n_twd)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", nm, act, req);
   endtask

   // Monitor: pops one expectation per cycle at the falling edge.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check({e.name, " rd1"}, b_rd1, e.e1);
         check({e.name, " rd2"}, b_rd2, e.e2);
         check({e.name, " nb rd1"}, n_rd1, e.n1);
         check({e.name, " nb rd2"}, n_rd2, e.n2);
         check({e.name, " trace_valid"}, {31'd0, b_tv}, {31'd0, e.tv});
         check({e.name, " nb trace_valid"}, {31'd0, n_tv}, {31'd0, e.tv});
         if (e.tv) begin
            check({e.name, " trace_pc"}, b_tpc, e.tpc);
            check({e.name, " trace_wa"}, {27'd0, b_twa}, {27'd0, e.twa});
            check({e.name, " trace_wd"}, b_twd, e.twd);
         end
         $display("%0t %s ra1=%0d ra2=%0d rd1=%08h rd2=%08h", $time, e.name, ra1, ra2, b_rd1, b_rd2);
         if (b_tv) $display("@%08h: $%2d <= %08h", b_tpc, b_twa, b_twd);
      end
   end

   task automatic drive(input logic r, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input logic [31:0] p,
                        input logic [4:0] a1, input logic [4:0] a2);
      reset = r; we = w; wa = a; wd = d; pc = p; ra1 = a1; ra2 = a2;
   endtask

   task automatic push(input string nm, input logic [31:0] e1, input logic [31:0] e2,
                       input logic [31:0] n1, input logic [31:0] n2, input logic tv);
      exp_t e;
      e.name = nm; e.e1 = e1; e.e2 = e2; e.n1 = n1; e.n2 = n2;
      e.tv = tv; e.tpc = pc; e.twd = wd; e.twa = wa;
      sb_q.push_back(e);
   endtask

   // Advance one edge, mirroring the commit into the random-phase model.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
      end else if (we && wa != 5'd0) begin
         model[wa] = wd;
      end
      #1;
   endtask

   function automatic logic [31:0] model_rd(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 32'h0;
      if (byp && we && !reset && wa != 5'd0 && wa == a) return wd;
      return model[a];
   endfunction

   // Contents after the directed writes of steps 2..5.
   function automatic logic [31:0] swept(input int i);
      case (i)
         8:       return 32'h12345678;
         9:       return 32'hAAAA5555;
         31:      return 32'h00003008;
         default: return 32'h00000000;
      endcase
   endfunction

   initial begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
      tick();

      // 1: reset state, then write dropped by a concurrent reset
      for (int i = 0; i < 32; i++) begin
         drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(31 - i));
         push("reset_sweep", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
         tick();
      end
      drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h00002FFC, 5'd5, 5'd5);
      push("reset_vs_write", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);
      push("reset_dropped", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();

      // 2: plain write to $8
      drive(1'b0, 1'b1, 5'd8, 32'h12345678, 32'h00003000, 5'd8, 5'd0);
      push("write8_same", 32'h12345678, 32'h0, 32'h0, 32'h0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd8);
      push("write8_after", 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1'b0);
      tick();

      // 3: write to $0 is ignored
      drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h00003004, 5'd0, 5'd0);
      push("write0_same", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
      push("write0_after", 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();

      // 4: same-cycle write and read of $9
      drive(1'b0, 1'b1, 5'd9, 32'h00000001, 32'h00003008, 5'd0, 5'd9);
      push("w9_init", 32'h0, 32'h00000001, 32'h0, 32'h0, 1'b1);
      tick();
      drive(1'b0, 1'b1, 5'd9, 32'hAAAA5555, 32'h0000300C, 5'd9, 5'd9);
      push("w9_bypass", 32'hAAAA5555, 32'hAAAA5555, 32'h00000001, 32'h00000001, 1'b1);
      tick();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9);
      push("w9_after", 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 32'hAAAA5555, 1'b0);
      tick();

      // 5: jal-style link write, then sweep all registers
      drive(1'b0, 1'b1, 5'd31, 32'h00003008, 32'h00003004, 5'd31, 5'd31);
      push("jal_same", 32'h00003008, 32'h00003008, 32'h0, 32'h0, 1'b1);
      tick();
      for (int i = 1; i < 32; i++) begin
         drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'd0);
         push("jal_sweep", swept(i), 32'h0, swept(i), 32'h0, 1'b0);
         tick();
      end

      // 6: random traffic against the model; resync model with a reset first
      drive(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
      tick();
      for (int c = 0; c < 1000; c++) begin
         drive(($urandom_range(0, 99) < 3), 1'($urandom), 5'($urandom), $urandom,
               32'h00400000 + 32'(c * 4), 5'($urandom), 5'($urandom));
         push("random", model_rd(ra1, 1'b1), model_rd(ra2, 1'b1),
              model_rd(ra1, 1'b0), model_rd(ra2, 1'b0),
              we && !reset && (wa != 5'd0));
         tick();
      end

      begin
         int guard = 0;
         while (sb_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
         end
         if (sb_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left expected 0", sb_q.size());
         end
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
